// File: rtl/elevator_shaft_model.sv
// Plant model of a four-floor elevator car and shaft.
// Receives the up/down/stop/open_door commands from an elevator controller.
// Drives the floor sensors S1..S4 that the controller reads.
// Models linear car travel, a timed door and protocol-violation detection.
//
// Ports:
//   clk, reset              rising-edge clock; asynchronous active-high reset
//   up, down, stop          motion commands from the controller
//   open_door               open the door, or hold it open
//   S1..S4                  car level with floor 1..4
//   car_floor[1:0]          floor index at or below the car
//   moving                  position changed on the last clock edge
//   door_closed             door fully closed
//   fault, fault_code[1:0]  sticky first violation:
//                           1 = up&down, 2 = overtravel, 3 = door
module elevator_shaft_model #(
   parameter int unsigned FLOOR_TICKS = 8,
   parameter int unsigned DOOR_TICKS  = 16,
   parameter int unsigned POS_W       = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       up,
   input  logic       down,
   input  logic       stop,
   input  logic       open_door,
   output logic       S1,
   output logic       S2,
   output logic       S3,
   output logic       S4,
   output logic [1:0] car_floor,
   output logic       moving,
   output logic       door_closed,
   output logic       fault,
   output logic [1:0] fault_code
);

   localparam int unsigned CNT_W = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
   localparam logic [POS_W-1:0] FT   = POS_W'(FLOOR_TICKS);
   localparam logic [POS_W-1:0] PMAX = POS_W'(3 * FLOOR_TICKS);

   typedef enum logic [1:0] {
      DOOR_CLOSED,
      DOOR_OPEN,
      DOOR_CLOSING
   } door_state_e;

   door_state_e      door_q, door_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             moving_q, moving_d;
   logic             fault_q, fault_d;
   logic [1:0]       code_q, code_d;
   logic [1:0]       mot_code;
   logic             door_viol;
   logic [1:0]       viol;
   logic             at_floor;
   logic [POS_W-1:0] quot;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         door_q   <= DOOR_CLOSED;
         pos_q    <= '0;
         cnt_q    <= '0;
         moving_q <= 1'b0;
         fault_q  <= 1'b0;
         code_q   <= '0;
      end else begin
         door_q   <= door_d;
         pos_q    <= pos_d;
         cnt_q    <= cnt_d;
         moving_q <= moving_d;
         fault_q  <= fault_d;
         code_q   <= code_d;
      end
   end

   // Sensor decode straight from the registered position
   always_comb begin
      S1        = (pos_q == '0);
      S2        = (pos_q == FT);
      S3        = (pos_q == POS_W'(2 * FLOOR_TICKS));
      S4        = (pos_q == PMAX);
      at_floor  = S1 | S2 | S3 | S4;
      quot      = pos_q / FT;
      car_floor = (quot > POS_W'(3)) ? 2'd3 : quot[1:0];
   end

   assign door_closed = (door_q == DOOR_CLOSED);
   assign moving      = moving_q;
   assign fault       = fault_q;
   assign fault_code  = code_q;

   always_comb begin
      pos_d     = pos_q;
      door_d    = door_q;
      cnt_d     = cnt_q;
      fault_d   = fault_q;
      code_d    = code_q;
      mot_code  = 2'd0;
      door_viol = 1'b0;

      // Motion, in priority order
      if (up && down) begin
         mot_code = 2'd1;
      end else if (stop) begin
         mot_code = 2'd0;
      end else if ((up || down) && !door_closed) begin
         mot_code = 2'd3;
      end else if (up) begin
         if (pos_q < PMAX) pos_d = pos_q + 1'b1;
         else              mot_code = 2'd2;
      end else if (down) begin
         if (pos_q != '0) pos_d = pos_q - 1'b1;
         else             mot_code = 2'd2;
      end

      // Door: the counter holds the edges still needed to close, so door_closed
      // rises exactly DOOR_TICKS edges after open_door is first sampled low.
      unique case (door_q)
         DOOR_CLOSED: begin
            if (open_door) begin
               if (at_floor) door_d = DOOR_OPEN;
               else          door_viol = 1'b1;
            end
         end
         DOOR_OPEN: begin
            if (!open_door) begin
               if (DOOR_TICKS == 1) begin
                  door_d = DOOR_CLOSED;
               end else begin
                  door_d = DOOR_CLOSING;
                  cnt_d  = CNT_W'(DOOR_TICKS - 1);
               end
            end
         end
         DOOR_CLOSING: begin
            if (open_door) begin
               door_d = DOOR_OPEN;
            end else if (cnt_q <= CNT_W'(1)) begin
               door_d = DOOR_CLOSED;
               cnt_d  = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: door_d = DOOR_CLOSED;
      endcase

      // Any motion violation code is <= 3, so it takes precedence over the door one
      viol = (mot_code != 2'd0) ? mot_code : (door_viol ? 2'd3 : 2'd0);
      if (!fault_q && (viol != 2'd0)) begin
         fault_d = 1'b1;
         code_d  = viol;
      end

      moving_d = (pos_d != pos_q);
   end

endmodule

// File: tb/tb_elevator_shaft_model.sv
module tb_elevator_shaft_model;

   localparam int FT   = 4;
   localparam int DT   = 3;
   localparam int PMAX = 3 * FT;

   logic clk, reset, up, down, stop, open_door;
   logic S1, S2, S3, S4, moving, door_closed, fault;
   logic [1:0] car_floor, fault_code;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int m_pos, m_rem, m_code;
   bit m_closed, m_moving, m_fault;

   elevator_shaft_model #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT), .POS_W(5)) dut (
      .clk(clk), .reset(reset), .up(up), .down(down), .stop(stop),
      .open_door(open_door), .S1(S1), .S2(S2), .S3(S3), .S4(S4),
      .car_floor(car_floor), .moving(moving), .door_closed(door_closed),
      .fault(fault), .fault_code(fault_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      int exp_s;
      int exp_f;
      exp_s = (m_pos % FT == 0) ? (1 << (m_pos / FT)) : 0;
      exp_f = (m_pos / FT > 3) ? 3 : m_pos / FT;
      check_val({tag, ".S"}, int'({S4, S3, S2, S1}), exp_s);
      check_val({tag, ".car_floor"}, int'(car_floor), exp_f);
      check_val({tag, ".moving"}, int'(moving), int'(m_moving));
      check_val({tag, ".door_closed"}, int'(door_closed), int'(m_closed));
      check_val({tag, ".fault"}, int'(fault), int'(m_fault));
      check_val({tag, ".fault_code"}, int'(fault_code), m_code);
   endtask

   task automatic model_reset();
      m_pos = 0; m_rem = -1; m_code = 0;
      m_closed = 1; m_moving = 0; m_fault = 0;
   endtask

   task automatic model_step(input bit u, input bit d, input bit s, input bit o);
      int code;
      int dcode;
      int new_pos;
      bit at;
      code = 0; dcode = 0; new_pos = m_pos;
      at = (m_pos % FT == 0);
      if (u && d)                  code = 1;
      else if (s)                  code = 0;
      else if ((u || d) && !m_closed) code = 3;
      else if (u)                  begin if (m_pos < PMAX) new_pos = m_pos + 1; else code = 2; end
      else if (d)                  begin if (m_pos > 0) new_pos = m_pos - 1; else code = 2; end
      // door: m_rem < 0 means held open, otherwise edges left until closed
      if (m_closed) begin
         if (o) begin
            if (at) begin m_closed = 0; m_rem = -1; end
            else dcode = 3;
         end
      end else if (o) begin
         m_rem = -1;
      end else begin
         m_rem = (m_rem < 0) ? DT - 1 : m_rem - 1;
         if (m_rem <= 0) begin m_closed = 1; m_rem = -1; end
      end
      if (code == 0) code = dcode;
      if (!m_fault && code != 0) begin m_fault = 1; m_code = code; end
      m_moving = (new_pos != m_pos);
      m_pos = new_pos;
   endtask

   task automatic step(input bit u, input bit d, input bit s, input bit o, input string tag);
      up = u; down = d; stop = s; open_door = o;
      @(posedge clk);
      model_step(u, d, s, o);
      #1;
      check_all(tag);
   endtask

   // Short asynchronous pulse between clock edges; outputs must snap without an edge
   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      reset = 1'b0;
   endtask

   initial begin
      up = 0; down = 0; stop = 0; open_door = 0; reset = 0;
      model_reset();
      #1;
      // 1: reset state
      do_reset("reset");
      // 2: full travel up
      for (int i = 0; i < 12; i++) step(1, 0, 0, 0, "climb");
      // 3: overtravel at the top
      for (int i = 0; i < 2; i++) step(1, 0, 0, 0, "overtravel");
      // 4: door cycle at floor 2, then motion with the door open
      do_reset("reset4");
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, "to_f2");
      for (int i = 0; i < 2; i++) step(0, 0, 0, 1, "door_open");
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "door_close");
      step(0, 0, 0, 1, "reopen");
      step(1, 0, 0, 1, "up_door_open");
      step(0, 0, 0, 0, "closing");
      step(0, 0, 0, 1, "reopen2");
      // 5: stop between floors, back down, then up&down
      do_reset("reset5");
      for (int i = 0; i < 2; i++) step(1, 0, 0, 0, "up2");
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, "stop_mid");
      for (int i = 0; i < 2; i++) step(0, 1, 0, 0, "down2");
      step(1, 1, 0, 0, "up_and_down");
      // 6: async reset mid-span and mid-closing
      do_reset("reset6");
      for (int i = 0; i < 6; i++) step(1, 0, 0, 0, "to_mid");
      do_reset("reset_midspan");
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, "to_f2b");
      step(0, 0, 0, 1, "open_b");
      step(0, 0, 0, 0, "closing_b");
      do_reset("reset_closing");
      // open_door off-floor and down at the bottom
      step(1, 0, 0, 0, "off_floor");
      step(0, 0, 0, 1, "open_off_floor");
      do_reset("reset7");
      step(0, 1, 0, 0, "down_at_bottom");
      // randomized closed-loop traffic
      do_reset("reset_rand");
      for (int i = 0; i < 800; i++) begin
         int r;
         bit u, d, s, o;
         if ($urandom_range(0, 59) == 0) do_reset("rand_reset");
         r = int'($urandom_range(0, 99));
         u = (r < 45);
         d = (r >= 40 && r < 75);
         s = ($urandom_range(0, 9) == 0);
         o = ($urandom_range(0, 5) == 0);
         step(u, d, s, o, "rand");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/elevator_shaft_model.md
Name: elevator_shaft_model

Overview:
Behavioural plant model of a four-floor elevator car and shaft. It is the other end of the elevator controller's interface: it consumes the controller's up/down/stop/open_door commands and produces the floor sensor lines S1..S4 that the controller reads. It models linear car travel between floors, a timed door, and protocol-violation checking. It is used in closed-loop simulation benches and as a board-level stand-in for the real shaft.

Parameters:
FLOOR_TICKS, 8, clock cycles of travel between adjacent floors (>=2)
DOOR_TICKS, 16, cycles the door needs to close after open_door drops (>=1)
POS_W, 5, width of the position counter; must hold 3*FLOOR_TICKS

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
up  input  1  controller command: move car up
down  input  1  controller command: move car down
stop  input  1  controller command: hold car
open_door  input  1  controller command: open or hold door open
S1  output  1  car level with floor 1
S2  output  1  car level with floor 2
S3  output  1  car level with floor 3
S4  output  1  car level with floor 4
car_floor  output  2  floor index at or below the car, 0..3
moving  output  1  position changed on the last clock edge
door_closed  output  1  door fully closed
fault  output  1  sticky protocol-violation flag
fault_code  output  2  first violation: 1 = up&down, 2 = overtravel, 3 = door violation

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is asynchronous and active-high.
- Position state: pos, 0..PMAX where PMAX = 3*FLOOR_TICKS. Floor k (1..4) is at pos = (k-1)*FLOOR_TICKS.
- Sensor decode from registered state, no extra latency:
  - Sk = (pos == (k-1)*FLOOR_TICKS).
  - car_floor = pos / FLOOR_TICKS, saturated to 3.
  - At most one Sk is high; all are low between floors.
- Reset values (asynchronous, immediate):
  - pos = 0, so S1 = 1 and S2..S4 = 0.
  - car_floor = 0, moving = 0, door_closed = 1, door counter = 0, fault = 0, fault_code = 0.
  - Reset mid-travel or mid-door snaps straight to this state.
- Door FSM, states CLOSED / OPEN / CLOSING:
  - CLOSED -> OPEN when open_door = 1 and some Sk = 1. door_closed falls at that edge.
  - OPEN stays while open_door = 1.
  - OPEN -> CLOSING when open_door = 0; counter loads DOOR_TICKS-1.
  - CLOSING decrements the counter each cycle. At 0 it goes to CLOSED; door_closed = 1 exactly DOOR_TICKS edges after the first edge that samples open_door = 0.
  - CLOSING -> OPEN if open_door reasserts. Reopening is allowed.
  - open_door = 1 with no Sk high: door stays CLOSED, violation code 3.
- Motion, evaluated each edge in this priority order:
  1. up & down: no motion, violation code 1.
  2. stop: no motion. Stopping between floors is legal; pos holds.
  3. up or down while door_closed = 0: no motion, violation code 3.
  4. up: if pos < PMAX, pos+1; else hold and raise violation code 2.
  5. down: if pos > 0, pos-1; else hold and raise violation code 2.
  6. None asserted: hold.
- Reversing direction mid-span is legal; pos simply counts the other way.
- moving is registered: 1 exactly on cycles following an edge where pos changed.
- Fault rules:
  - fault sets on the first violation and stays set until reset.
  - fault_code latches the first violation only.
  - If two violations occur on the same edge, the lower code wins.
- Arithmetic: pos is unsigned POS_W bits and never wraps; it saturates at 0 and PMAX.

Test Plan:
(FLOOR_TICKS=4, DOOR_TICKS=3)
1. Reset pulse, all inputs 0 -> S1=1, S2..S4=0, car_floor=0, door_closed=1, fault=0, moving=0.
2. Hold up for 12 edges -> S1 falls after edge 1; S2=1 after edge 4 with car_floor=1; S3=1 after edge 8; S4=1 after edge 12 with car_floor=3; moving=1 throughout; fault=0.
3. At pos 12, up for 2 more edges -> pos stays 12, S4=1, moving=0, fault=1, fault_code=2.
4. At floor 2, open_door=1 for 2 edges, then 0 -> door_closed=0 after the first edge and returns to 1 exactly 3 edges after open_door drops. Asserting up while the door is open -> pos unchanged, fault_code=3.
5. From reset: up 2 edges, then stop with up still high for 3 edges, then down 2 edges -> pos=2 during stop with all Sk low and moving=0; S1=1 after the down edges; fault=0. Then up=down=1 for one edge -> fault_code=1, pos unchanged.
6. Async reset asserted mid-span (pos=6) and mid-CLOSING -> immediately pos=0, S1=1, door_closed=1, fault cleared, with no clock edge needed.
